// File: rtl/cmp_sweep_checker.sv
// Exhaustive sweep BIST for a WIDTH-bit magnitude comparator.
// Define CMP_CHECK_FIRST_FAIL_EN to capture the first failing pair.
module cmp_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_flags
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST =
    4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam state_t FIRST =
    (SETTLE_CYCLES == 0) ? CHECK : APPLY;

  state_t            state;
  logic [3:0]        settle;
  logic [2:0]        flags;
  logic [2:0]        ref_flags;
  logic              miss;
  logic              last;
  logic              accept;
  logic [2*WIDTH-1:0] index;

  assign flags     = {cmp_eq, cmp_lt, cmp_gt};
  assign ref_flags = {cmp_a == cmp_b, cmp_a < cmp_b, cmp_a > cmp_b};
  assign miss      = (flags != ref_flags);
  assign index     = {cmp_a, cmp_b};
  assign last      = &index;
  assign accept    = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      settle    <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FIRST;
            settle    <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
          end
        end
        APPLY: begin
          if (settle == SETTLE_LAST) begin
            state  <= CHECK;
            settle <= '0;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        CHECK: begin
          err_count <= err_count + {{(2*WIDTH){1'b0}}, miss};
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !miss;
          end else begin
            {cmp_a, cmp_b} <= index + 1'b1;
            state          <= FIRST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_CHECK_FIRST_FAIL_EN
  // A zero count at a mismatching CHECK marks the first failure of the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a     <= '0;
      fail_b     <= '0;
      fail_flags <= '0;
    end else if (accept) begin
      fail_a     <= '0;
      fail_b     <= '0;
      fail_flags <= '0;
    end else if (state == CHECK && miss && err_count == '0) begin
      fail_a     <= cmp_a;
      fail_b     <= cmp_b;
      fail_flags <= flags;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign fail_a        = '0;
  assign fail_b        = '0;
  assign fail_flags    = '0;
`endif

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Scoreboard bench for cmp_sweep_checker with a faultable comparator
// model; one instance at SETTLE_CYCLES=1 and one at SETTLE_CYCLES=0.
module tb_cmp_sweep_checker;

`ifdef CMP_CHECK_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] a0, b0, a1, b1;
  logic       eq0, lt0, gt0, eq1, lt1, gt1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] err0, err1;
  logic [3:0] fa0, fb0, fa1, fb1;
  logic [2:0] ff0, ff1;
  int         mode0 = 0;
  int         mode1 = 0;

  typedef struct {
    int err;
    int pass;
    int fa;
    int fb;
    int ff;
    int lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sc0 = 0;
  int   sc1 = 0;
  bit   busy_bad0 = 1'b0;
  logic dprev0 = 1'b0;
  logic dprev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode: 0 good, 1 eq stuck 0, 2 lt/gt swapped, 3 gt tied 1
  always_comb begin
    eq0 = (a0 == b0);
    lt0 = (a0 < b0);
    gt0 = (a0 > b0);
    case (mode0)
      1: eq0 = 1'b0;
      2: begin
        lt0 = (a0 > b0);
        gt0 = (a0 < b0);
      end
      3: gt0 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    eq1 = (a1 == b1);
    lt1 = (a1 < b1);
    gt1 = (a1 > b1);
    if (mode1 == 3) gt1 = 1'b1;
  end

  cmp_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .cmp_a(a0), .cmp_b(b0),
    .cmp_eq(eq0), .cmp_lt(lt0), .cmp_gt(gt0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0),
    .fail_a(fa0), .fail_b(fb0), .fail_flags(ff0)
  );

  cmp_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .cmp_a(a1), .cmp_b(b1),
    .cmp_eq(eq1), .cmp_lt(lt1), .cmp_gt(gt1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1),
    .fail_a(fa1), .fail_b(fb1), .fail_flags(ff1)
  );

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0 && cyc >= sc0 && !done0 && !busy0)
      busy_bad0 = 1'b1;
    if (done0 && !dprev0 && q0.size() != 0) begin
      e = q0.pop_front();
      chk("latency0", cyc - sc0, e.lat);
      chk("err_count0", int'(err0), e.err);
      chk("pass0", int'(pass0), e.pass);
      chk("fail_a0", int'(fa0), e.fa);
      chk("fail_b0", int'(fb0), e.fb);
      chk("fail_flags0", int'(ff0), e.ff);
      chk("busy_held0", int'(busy_bad0), 0);
      busy_bad0 = 1'b0;
    end
    dprev0 = done0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1 && !dprev1 && q1.size() != 0) begin
      e = q1.pop_front();
      chk("latency1", cyc - sc1, e.lat);
      chk("err_count1", int'(err1), e.err);
      chk("pass1", int'(pass1), e.pass);
    end
    dprev1 = done1;
  end

  task automatic run0(int m, int e_err, int fa, int fb, int ff);
    exp_t e;
    mode0 = m;
    @(posedge clk);
    #1;
    sc0    = cyc + 1;
    e.err  = e_err;
    e.pass = (e_err == 0) ? 1 : 0;
    e.fa   = FF_EN ? fa : 0;
    e.fb   = FF_EN ? fb : 0;
    e.ff   = FF_EN ? ff : 0;
    e.lat  = 512;
    q0.push_back(e);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int i = 0; i < 3000 && q0.size() != 0; i++) @(posedge clk);
    chk("timeout0", q0.size(), 0);
    q0.delete();
  endtask

  task automatic run1(int m, int e_err, bit clear_chk);
    exp_t e;
    @(posedge clk);
    #1;
    mode1  = m;
    sc1    = cyc + 1;
    e.err  = e_err;
    e.pass = (e_err == 0) ? 1 : 0;
    e.fa   = 0;
    e.fb   = 0;
    e.ff   = 0;
    e.lat  = 256;
    q1.push_back(e);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    if (clear_chk) begin
      chk("restart_done1", int'(done1), 0);
      chk("restart_err1", int'(err1), 0);
    end
    for (int i = 0; i < 1500 && q1.size() != 0; i++) @(posedge clk);
    chk("timeout1", q1.size(), 0);
    q1.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0",
        int'({a0, b0, busy0, done0, pass0, err0, fa0, fb0, ff0}), 0);
    rst_n = 1'b1;

    run0(0, 0, 0, 0, 0);
    run0(1, 16, 0, 0, 0);
    run0(2, 240, 0, 1, 1);
    run0(3, 136, 0, 0, 5);
    run0(0, 0, 0, 0, 0);

    mode0 = 0;
    @(posedge clk);
    #1;
    start0 = 1'b1;
    repeat (201) @(posedge clk);
    #1;
    chk("abort_index", int'({a0, b0}), 100);
    chk("abort_busy", int'(busy0), 1);
    chk("abort_err", int'(err0), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_outs0",
        int'({a0, b0, busy0, done0, pass0, err0, fa0, fb0, ff0}), 0);
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run0(0, 0, 0, 0, 0);

    run1(3, 136, 1'b0);
    run1(0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
